// File: rtl/uart_rsp_deframer_pkg.sv
// Shared types and constants for the UART response deframer.
// Holds the bit FSM encoding, parity selection and legal oversampling ratios.
package uart_rsp_deframer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic prescale_ok(input int p);
    return (p == PRESCALE_8) ||
           (p == PRESCALE_16) ||
           (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Per-bit edge counter with a 3-sample majority vote around the bit centre.
// bit_done pulses on the last of the three samples, with bit_val valid alongside.
module uart_bit_sampler
  import uart_rsp_deframer_pkg::*;
#(
  parameter int PRESCALE_WD = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   restart,
  input  logic [PRESCALE_WD-1:0] prescale,
  input  logic                   rx,
  output logic                   bit_done,
  output logic                   bit_val
);

  localparam logic [PRESCALE_WD-1:0] ONE = 1;

  logic [PRESCALE_WD-1:0] cnt;
  logic [PRESCALE_WD-1:0] half;
  logic [PRESCALE_WD-1:0] h_m1;
  logic [PRESCALE_WD-1:0] h_p1;
  logic [PRESCALE_WD-1:0] last;
  logic                   s0;
  logic                   s1;

  assign half = prescale >> 1;
  assign h_m1 = half - ONE;
  assign h_p1 = half + ONE;
  assign last = prescale - ONE;

  // The start-edge cycle counts as edge 0, so the counter restarts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      s0  <= 1'b1;
      s1  <= 1'b1;
    end else if (restart) begin
      cnt <= ONE;
    end else if (en) begin
      cnt <= (cnt == last) ? '0 : cnt + ONE;
      if (cnt == h_m1) s0 <= rx;
      if (cnt == half) s1 <= rx;
    end
  end

  assign bit_done = en && !restart && (cnt == h_p1);
  assign bit_val  = maj3(s0, s1, rx);

endmodule

// File: rtl/uart_rsp_deframer.sv
// Oversampling UART receiver assembling 1- or 2-byte host responses.
// Flags parity, framing, overrun and inter-byte timeout as 1-cycle pulses.
module uart_rsp_deframer
  import uart_rsp_deframer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int PRESCALE_WD  = 6,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    SER_IN,
  input  logic [PRESCALE_WD-1:0]  Prescale,
  input  logic                    PAR_EN,
  input  logic                    PAR_TYP,
  input  logic                    RSP_WORD,
  input  logic                    RSP_READY,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_VALID,
  output logic                    PAR_ERR,
  output logic                    FRM_ERR,
  output logic                    OVERRUN,
  output logic                    TIMEOUT
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_WD-1:0] ONE = 1;
  localparam logic [PRESCALE_WD-1:0] P_DEF = PRESCALE_WD'(PRESCALE_16);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_BITS - 1);

  logic                   rx_meta;
  logic                   rx_sync;
  logic                   rx_prev;
  state_t                 state_q;
  state_t                 state_d;
  logic [PRESCALE_WD-1:0] presc_q;
  logic [PRESCALE_WD-1:0] presc_cap;
  logic                   pen_q;
  logic                   ptyp_q;
  logic                   word_q;
  logic [DATA_WIDTH-1:0]  shift_q;
  logic [DATA_WIDTH-1:0]  lo_q;
  logic [BIT_W-1:0]       bit_cnt_q;
  logic                   perr_q;
  logic                   idx_q;
  logic [PRESCALE_WD-1:0] to_cyc_q;
  logic [31:0]            to_bits_q;

  logic                    bit_done;
  logic                    bit_val;
  logic                    start_det;
  logic                    exp_par;
  logic                    stop_hit;
  logic                    frm_hit;
  logic                    par_hit;
  logic                    acc;
  logic                    cmp;
  logic                    waiting;
  logic                    bit_tick;
  logic                    to_hit;
  logic [2*DATA_WIDTH-1:0] rsp_new;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= SER_IN;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_det = (state_q == IDLE) && rx_prev && !rx_sync;
  assign presc_cap = prescale_ok(int'(Prescale)) ? Prescale : P_DEF;

  uart_bit_sampler #(
    .PRESCALE_WD(PRESCALE_WD)
  ) u_sampler (
    .clk      (CLK),
    .rst_n    (RST),
    .en       (state_q != IDLE),
    .restart  (start_det),
    .prescale (presc_q),
    .rx       (rx_sync),
    .bit_done (bit_done),
    .bit_val  (bit_val)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start_det) state_d = START;
      START:  if (bit_done) state_d = bit_val ? IDLE : DATA;
      DATA: begin
        if (bit_done && (bit_cnt_q == LAST_BIT))
          state_d = pen_q ? PARITY : STOP;
      end
      PARITY: if (bit_done) state_d = STOP;
      STOP:   if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign exp_par  = (^shift_q) ^ (ptyp_q == PAR_ODD);
  assign stop_hit = (state_q == STOP) && bit_done;
  assign frm_hit  = stop_hit && !bit_val;
  assign par_hit  = stop_hit && bit_val && perr_q;
  assign acc      = stop_hit && bit_val && !perr_q;
  assign cmp      = acc && (idx_q || !word_q);
  assign rsp_new  = idx_q ? {shift_q, lo_q}
                          : {{DATA_WIDTH{1'b0}}, shift_q};

  // Timeout counts bit times only while idle between byte 0 and byte 1.
  assign waiting  = (state_q == IDLE) && idx_q && !start_det;
  assign bit_tick = (to_cyc_q == presc_q - ONE);
  assign to_hit   = waiting && bit_tick && (to_bits_q == TO_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q   <= P_DEF;
      pen_q     <= 1'b0;
      ptyp_q    <= PAR_EVEN;
      word_q    <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      perr_q    <= 1'b0;
    end else begin
      if (start_det) begin
        presc_q   <= presc_cap;
        pen_q     <= PAR_EN;
        ptyp_q    <= PAR_TYP;
        perr_q    <= 1'b0;
        bit_cnt_q <= '0;
        if (!idx_q) word_q <= RSP_WORD;
      end
      if ((state_q == DATA) && bit_done) begin
        shift_q   <= {bit_val, shift_q[DATA_WIDTH-1:1]};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if ((state_q == PARITY) && bit_done && (bit_val != exp_par))
        perr_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      idx_q     <= 1'b0;
      lo_q      <= '0;
      to_cyc_q  <= '0;
      to_bits_q <= '0;
    end else begin
      if (frm_hit || par_hit || to_hit) begin
        idx_q <= 1'b0;
      end else if (acc) begin
        if (idx_q) begin
          idx_q <= 1'b0;
        end else begin
          lo_q  <= shift_q;
          idx_q <= word_q;
        end
      end
      if (!waiting) begin
        to_cyc_q  <= '0;
        to_bits_q <= '0;
      end else if (bit_tick) begin
        to_cyc_q  <= '0;
        to_bits_q <= to_hit ? '0 : to_bits_q + 1'b1;
      end else begin
        to_cyc_q  <= to_cyc_q + ONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RSP_DATA  <= '0;
      RSP_VALID <= 1'b0;
      PAR_ERR   <= 1'b0;
      FRM_ERR   <= 1'b0;
      OVERRUN   <= 1'b0;
      TIMEOUT   <= 1'b0;
    end else begin
      PAR_ERR <= par_hit;
      FRM_ERR <= frm_hit;
      TIMEOUT <= to_hit;
      OVERRUN <= cmp && RSP_VALID && !RSP_READY;
      if (cmp && (!RSP_VALID || RSP_READY)) begin
        RSP_DATA  <= rsp_new;
        RSP_VALID <= 1'b1;
      end else if (RSP_VALID && RSP_READY) begin
        RSP_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rsp_deframer.sv
// Directed bench for uart_rsp_deframer: serial frames in, scoreboarded responses out.
// A monitor pops expected responses on each handshake; error pulses are tallied.
module tb_uart_rsp_deframer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        SER_IN = 1'b1;
  logic [5:0]  Prescale = 6'd16;
  logic        PAR_EN = 1'b0;
  logic        PAR_TYP = 1'b0;
  logic        RSP_WORD = 1'b0;
  logic        RSP_READY = 1'b1;
  logic [15:0] RSP_DATA;
  logic        RSP_VALID;
  logic        PAR_ERR;
  logic        FRM_ERR;
  logic        OVERRUN;
  logic        TIMEOUT;

  int checks = 0;
  int errors = 0;
  int par_n = 0;
  int frm_n = 0;
  int ovr_n = 0;
  int to_n = 0;
  int vld_n = 0;
  int hs_n = 0;
  logic [15:0] exp_q[$];

  uart_rsp_deframer dut (
    .CLK       (CLK),
    .RST       (RST),
    .SER_IN    (SER_IN),
    .Prescale  (Prescale),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .RSP_WORD  (RSP_WORD),
    .RSP_READY (RSP_READY),
    .RSP_DATA  (RSP_DATA),
    .RSP_VALID (RSP_VALID),
    .PAR_ERR   (PAR_ERR),
    .FRM_ERR   (FRM_ERR),
    .OVERRUN   (OVERRUN),
    .TIMEOUT   (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      if (PAR_ERR) par_n++;
      if (FRM_ERR) frm_n++;
      if (OVERRUN) ovr_n++;
      if (TIMEOUT) to_n++;
      if (RSP_VALID) vld_n++;
      if (RSP_VALID && RSP_READY) begin
        hs_n++;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", {16'h0, RSP_DATA}, 32'hdead);
        end else begin
          chk("rsp_data", {16'h0, RSP_DATA}, {16'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic bit_out(input logic v, input int p);
    SER_IN = v;
    repeat (p) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] b, input int p, input logic pen,
                      input logic ptyp, input logic bad_par,
                      input logic bad_stop);
    logic pb;
    Prescale = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    pb = (ptyp ? ~^b : ^b) ^ bad_par;
    bit_out(1'b0, p);
    for (int i = 0; i < 8; i++) bit_out(b[i], p);
    if (pen) bit_out(pb, p);
    bit_out(~bad_stop, p);
    bit_out(1'b1, 2 * p);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_valid", {31'h0, RSP_VALID}, 32'h0);
    chk("reset_out", {12'h0, PAR_ERR, FRM_ERR, OVERRUN, TIMEOUT, RSP_DATA}, 32'h0);
    RST = 1'b1;
    repeat (4) @(negedge CLK);

    // 1: single byte, P16, no parity, consumer always ready
    RSP_WORD = 1'b0;
    exp_q.push_back(16'h00A5);
    send(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_valid_cycles", vld_n, 1);
    chk("t1_handshakes", hs_n, 1);

    // 2: word response, P8, even parity
    RSP_WORD = 1'b1;
    exp_q.push_back(16'h1234);
    send(8'h34, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'h12, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_handshakes", hs_n, 2);
    chk("t2_no_errors", par_n + frm_n + ovr_n + to_n, 0);

    // 3: odd parity, wrong parity bit, then a good byte
    RSP_WORD = 1'b0;
    send(8'h0F, 16, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_par_err", par_n, 1);
    chk("t3_no_rsp", hs_n, 2);
    exp_q.push_back(16'h0055);
    send(8'h55, 16, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_handshakes", hs_n, 3);

    // 4: framing error, then a short glitch on an idle line
    send(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_frm_err", frm_n, 1);
    bit_out(1'b0, 3);
    bit_out(1'b1, 48);
    chk("t4_glitch_errs", par_n + frm_n + to_n, 2);
    chk("t4_glitch_rsp", hs_n, 3);

    // 5: inter-byte timeout, then a complete word
    RSP_WORD = 1'b1;
    send(8'h77, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    bit_out(1'b1, 29 * 16);
    chk("t5_no_early_to", to_n, 0);
    bit_out(1'b1, 9 * 16);
    chk("t5_timeout", to_n, 1);
    chk("t5_no_rsp", hs_n, 3);
    exp_q.push_back(16'h0201);
    send(8'h01, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h02, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_handshakes", hs_n, 4);

    // 6: overrun with consumer stalled, then reset mid-frame
    RSP_WORD  = 1'b0;
    RSP_READY = 1'b0;
    exp_q.push_back(16'h0011);
    send(8'h11, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h22, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_overrun", ovr_n, 1);
    chk("t6_held_data", {16'h0, RSP_DATA}, 32'h0011);
    chk("t6_held_valid", {31'h0, RSP_VALID}, 32'h1);
    SER_IN = 1'b0;
    repeat (20) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("t6_rst_valid", {31'h0, RSP_VALID}, 32'h0);
    chk("t6_rst_out", {12'h0, PAR_ERR, FRM_ERR, OVERRUN, TIMEOUT, RSP_DATA}, 32'h0);
    exp_q.delete();
    SER_IN = 1'b1;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    RSP_READY = 1'b1;
    repeat (4) @(negedge CLK);

    // recovery after reset
    exp_q.push_back(16'h005A);
    send(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rec_handshakes", hs_n, 5);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
